// File: rtl/window_gen_5x5_6bit_if.sv
// Pixel-in / window-out stream bundle for window_gen_5x5_6bit.
// slave = the window generator, master = the pixel source / window sink side.
interface window_gen_5x5_6bit_if;
  logic         pix_valid;
  logic         pix_ready;
  logic         pix_sof;
  logic [5:0]   pix_data;
  logic         win_valid;
  logic         win_ready;
  logic [149:0] win_data;
  logic         frame_done;

  modport master (
    output pix_valid, pix_sof, pix_data, win_ready,
    input  pix_ready, win_valid, win_data, frame_done
  );

  modport slave (
    input  pix_valid, pix_sof, pix_data, win_ready,
    output pix_ready, win_valid, win_data, frame_done
  );
endinterface

// File: rtl/window_gen_5x5_6bit.sv
// Streaming 5x5 window generator: four line buffers plus a 5x5 shift array feeding a 6-bit conv block.
// Optional kernel register file is enabled by defining WINGEN_KERNEL_REGS_EN.
module window_gen_5x5_6bit #(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  window_gen_5x5_6bit_if.slave  bus
`ifdef WINGEN_KERNEL_REGS_EN
  ,
  input  logic                  kern_we,
  input  logic [4:0]            kern_addr,
  input  logic [5:0]            kern_wdata,
  output logic [149:0]          kern_data
`endif
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_FIRST_WIN = CW'(4);
  localparam logic [RW-1:0] ROW_FIRST_WIN = RW'(4);

  logic [CW-1:0]  col, pos_col;
  logic [RW-1:0]  row, pos_row;
  logic           accept, win_hit, last_pix;
  logic [5:0]     lb [4][IMG_W];
  logic [5:0]     arr [5][5];
  logic [5:0]     arr_nxt [5][5];
  logic [149:0]   win_flat;

  assign bus.pix_ready = !bus.win_valid || bus.win_ready;
  assign accept        = bus.pix_valid && bus.pix_ready;

  // sof pins the current pixel to (0,0) whatever the counters say
  assign pos_col  = bus.pix_sof ? '0 : col;
  assign pos_row  = bus.pix_sof ? '0 : row;
  assign win_hit  = (pos_row >= ROW_FIRST_WIN) && (pos_col >= COL_FIRST_WIN);
  assign last_pix = (pos_row == ROW_LAST) && (pos_col == COL_LAST);

  always_comb begin
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 4; c++) begin
        arr_nxt[r][c] = arr[r][c+1];
      end
    end
    // newest column: r=0 is the oldest row (lb[3]), r=4 is the live pixel
    for (int r = 0; r < 4; r++) begin
      arr_nxt[r][4] = lb[3-r][pos_col];
    end
    arr_nxt[4][4] = bus.pix_data;
  end

  always_comb begin
    win_flat = '0;
    for (int k = 0; k < 25; k++) begin
      win_flat[6*k +: 6] = arr_nxt[k/5][k%5];
    end
  end

  // storage without reset: contents are only exposed after four fresh rows
  always_ff @(posedge clk) begin
    if (accept) begin
      lb[0][pos_col] <= bus.pix_data;
      for (int i = 1; i < 4; i++) begin
        lb[i][pos_col] <= lb[i-1][pos_col];
      end
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 5; c++) begin
          arr[r][c] <= arr_nxt[r][c];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col            <= '0;
      row            <= '0;
      bus.win_valid  <= 1'b0;
      bus.win_data   <= '0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.frame_done <= accept && last_pix;
      if (accept) begin
        if (pos_col == COL_LAST) begin
          col <= '0;
          row <= (pos_row == ROW_LAST) ? '0 : pos_row + 1'b1;
        end else begin
          col <= pos_col + 1'b1;
          row <= pos_row;
        end
      end
      if (accept && win_hit) begin
        bus.win_valid <= 1'b1;
        bus.win_data  <= win_flat;
      end else if (bus.win_ready) begin
        bus.win_valid <= 1'b0;
      end
    end
  end

`ifdef WINGEN_KERNEL_REGS_EN
  logic [5:0] kern_regs [25];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 25; k++) begin
        kern_regs[k] <= '0;
      end
    end else if (kern_we && (kern_addr <= 5'd24)) begin
      kern_regs[kern_addr] <= kern_wdata;
    end
  end

  always_comb begin
    kern_data = '0;
    for (int k = 0; k < 25; k++) begin
      kern_data[6*k +: 6] = kern_regs[k];
    end
  end
`endif

endmodule

// File: tb/tb_window_gen_5x5_6bit.sv
// Self-checking bench for window_gen_5x5_6bit on an 8x8 image against a frame-array reference model.
// Kernel register checks are compiled in when WINGEN_KERNEL_REGS_EN is defined.
module tb_window_gen_5x5_6bit;
  localparam int W = 8;
  localparam int H = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  window_gen_5x5_6bit_if bus();

`ifdef WINGEN_KERNEL_REGS_EN
  logic         kern_we = 1'b0;
  logic [4:0]   kern_addr = '0;
  logic [5:0]   kern_wdata = '0;
  logic [149:0] kern_data;
`endif

  window_gen_5x5_6bit #(.IMG_W(W), .IMG_H(H)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef WINGEN_KERNEL_REGS_EN
    ,
    .kern_we    (kern_we),
    .kern_addr  (kern_addr),
    .kern_wdata (kern_wdata),
    .kern_data  (kern_data)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  int mrow = 0, mcol = 0;
  logic [5:0] img [H][W];
  logic [149:0] exp_q [$];
  bit fd_exp = 1'b0;
  int win_cnt = 0, fd_cnt = 0;
  bit rnd_mode = 1'b0;
  bit dummy;
  int w0, f0;
  logic [149:0] hold;

  function automatic logic [149:0] ref_win(int r, int c);
    logic [149:0] v;
    v = '0;
    for (int k = 0; k < 25; k++) v[6*k +: 6] = img[r-4+k/5][c-4+k%5];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [149:0] obs, input logic [149:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    fd_exp = 1'b0;
    mrow = 0;
    mcol = 0;
  endtask

  // one clock: check outputs at negedge, update the model, return whether a pixel was accepted
  task automatic tick(output bit acc);
    bit exp_rdy, fd_nxt;
    @(negedge clk);
    exp_rdy = (exp_q.size() == 0) || bus.win_ready;
    chk("pix_ready", {149'b0, bus.pix_ready}, {149'b0, exp_rdy});
    chk("win_valid", {149'b0, bus.win_valid}, {149'b0, exp_q.size() != 0});
    if (exp_q.size() != 0) chk("win_data", bus.win_data, exp_q[0]);
    chk("frame_done", {149'b0, bus.frame_done}, {149'b0, fd_exp});
    if (bus.frame_done === 1'b1) fd_cnt++;
    if (exp_q.size() != 0 && bus.win_ready) begin
      void'(exp_q.pop_front());
      win_cnt++;
    end
    acc = bus.pix_valid && exp_rdy;
    fd_nxt = 1'b0;
    if (acc) begin
      if (bus.pix_sof) begin
        mrow = 0;
        mcol = 0;
      end
      img[mrow][mcol] = bus.pix_data;
      if (mrow >= 4 && mcol >= 4) exp_q.push_back(ref_win(mrow, mcol));
      fd_nxt = (mrow == H-1) && (mcol == W-1);
      if (mcol == W-1) begin
        mcol = 0;
        mrow = (mrow == H-1) ? 0 : mrow + 1;
      end else begin
        mcol++;
      end
    end
    @(posedge clk);
    fd_exp = fd_nxt;
    #1;
  endtask

  task automatic idle(input int n);
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
    repeat (n) tick(dummy);
  endtask

  task automatic send(input logic [5:0] d, input bit sof);
    bit acc;
    int tries;
    if (rnd_mode) begin
      bus.pix_valid = 1'b0;
      repeat ($urandom_range(0, 1)) begin
        bus.win_ready = ($urandom % 4) != 0;
        tick(dummy);
      end
    end
    bus.pix_valid = 1'b1;
    bus.pix_data  = d;
    bus.pix_sof   = sof;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 50) begin
      if (rnd_mode) bus.win_ready = ($urandom % 4) != 0;
      tick(acc);
      tries++;
    end
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $error("FAIL send_timeout: observed no accept expected accept within 50 cycles");
    end
    bus.pix_sof = 1'b0;
  endtask

  task automatic send_frame(input bit pattern);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        send(pattern ? 6'(8*r + c) : 6'($urandom), (r == 0) && (c == 0));
  endtask

  initial begin
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
    bus.pix_data  = '0;
    bus.win_ready = 1'b1;
    #2;
    chk("rst_pix_ready", {149'b0, bus.pix_ready}, 150'd1);
    chk("rst_win_valid", {149'b0, bus.win_valid}, 150'd0);
    chk("rst_frame_done", {149'b0, bus.frame_done}, 150'd0);
    chk("rst_win_data", bus.win_data, 150'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();

    // frame A: pixel value 8r+c, back to back
    w0 = win_cnt; f0 = fd_cnt;
    for (int i = 0; i < W*H; i++) begin
      send(6'(i), i == 0);
      if (i == 36) begin
        chk("first_slot0",  {144'b0, bus.win_data[5:0]},     150'd0);
        chk("first_slot12", {144'b0, bus.win_data[77:72]},   150'd18);
        chk("first_slot24", {144'b0, bus.win_data[149:144]}, 150'd36);
      end
      if (i == 37) begin
        chk("second_slot0",  {144'b0, bus.win_data[5:0]},     150'd1);
        chk("second_slot24", {144'b0, bus.win_data[149:144]}, 150'd37);
      end
    end
    idle(3);
    chk("frameA_windows", 150'(win_cnt - w0), 150'd16);
    chk("frameA_done",    150'(fd_cnt - f0),  150'd1);

    // frame B: random pixels with a 3-cycle downstream stall mid-frame
    w0 = win_cnt; f0 = fd_cnt;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        send(6'($urandom), (r == 0) && (c == 0));
        if (r == 5 && c == 4) begin
          hold = bus.win_data;
          bus.win_ready = 1'b0;
          bus.pix_valid = 1'b1;
          bus.pix_data  = 6'($urandom);
          repeat (3) begin
            tick(dummy);
            chk("stall_hold", bus.win_data, hold);
            chk("stall_ready", {149'b0, bus.pix_ready}, 150'd0);
          end
          bus.win_ready = 1'b1;
          bus.pix_valid = 1'b0;
        end
      end
    idle(3);
    chk("frameB_windows", 150'(win_cnt - w0), 150'd16);
    chk("frameB_done",    150'(fd_cnt - f0),  150'd1);

    // frame C: random valid gaps and random backpressure
    rnd_mode = 1'b1;
    w0 = win_cnt; f0 = fd_cnt;
    send_frame(1'b0);
    rnd_mode = 1'b0;
    bus.win_ready = 1'b1;
    idle(3);
    chk("frameC_windows", 150'(win_cnt - w0), 150'd16);
    chk("frameC_done",    150'(fd_cnt - f0),  150'd1);

    // sof resync at old position (5,2): 4 windows from row 4, then a full new frame
    w0 = win_cnt; f0 = fd_cnt;
    for (int i = 0; i < 42; i++) send(6'($urandom), i == 0);
    send_frame(1'b0);
    chk("resync_fd_high", {149'b0, bus.frame_done}, 150'd1);
    chk("resync_windows", 150'(win_cnt - w0 + exp_q.size()), 150'd20);
    chk("resync_done",    150'(fd_cnt - f0 + 1), 150'd1);

    // async reset between edges while win_valid and frame_done are both high
    bus.pix_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("arst_win_valid",  {149'b0, bus.win_valid},  150'd0);
    chk("arst_frame_done", {149'b0, bus.frame_done}, 150'd0);
    chk("arst_pix_ready",  {149'b0, bus.pix_ready},  150'd1);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // partial frame, reset mid-frame, then a clean frame
    for (int i = 0; i < 45; i++) send(6'($urandom), i == 0);
    bus.pix_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst2_win_valid", {149'b0, bus.win_valid}, 150'd0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    w0 = win_cnt; f0 = fd_cnt;
    send_frame(1'b0);
    idle(3);
    chk("postrst_windows", 150'(win_cnt - w0), 150'd16);
    chk("postrst_done",    150'(fd_cnt - f0),  150'd1);

`ifdef WINGEN_KERNEL_REGS_EN
    chk("kern_reset", kern_data, 150'd0);
    kern_we = 1'b1; kern_addr = 5'd24; kern_wdata = 6'h3F;
    @(posedge clk); #1;
    kern_addr = 5'd25; kern_wdata = 6'h15;
    chk("kern_wr24", kern_data, {6'h3F, 144'b0});
    @(posedge clk); #1;
    kern_addr = 5'd3; kern_wdata = 6'h2A;
    chk("kern_wr25_ignored", kern_data, {6'h3F, 144'b0});
    @(posedge clk); #1;
    kern_we = 1'b0;
    chk("kern_wr3", kern_data, {6'h3F, 120'b0, 6'h2A, 18'b0});
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
